// File: rtl/bcd_pkg.sv
// Shared BCD types and helpers for the serial BCD add/subtract datapath.
package bcd_pkg;

    typedef logic [3:0] bcd_digit_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ADD  = 2'd1,
        S_COMP = 2'd2,
        S_DONE = 2'd3
    } bcd_state_e;

    localparam bcd_digit_t BCD_NINE = 4'd9;
    localparam logic [4:0] BCD_TEN  = 5'd10;

    // A packed nibble is a legal decimal digit only in the range 0..9.
    function automatic logic bcd_is_valid(input bcd_digit_t digit);
        return digit <= BCD_NINE;
    endfunction

endpackage

// File: rtl/bcd_digit_adder.sv
// Single-digit BCD adder: binary add of two digits plus carry, then decimal correction.
module bcd_digit_adder
    import bcd_pkg::*;
(
    input  bcd_digit_t x,
    input  bcd_digit_t y,
    input  logic       carryIn,
    output bcd_digit_t digit,
    output logic       carryOut
);

    logic [4:0] binSum;

    // Binary sum (max 9+9+1 = 19) folded back into one decimal digit and a carry.
    // NOTE: every output of a combinational block is assigned on every path, so no latch is inferred.
    always_comb begin
        binSum   = {1'b0, x} + {1'b0, y} + {4'b0000, carryIn};
        carryOut = (binSum >= BCD_TEN);
        // Subtracting ten modulo 16 on the low nibble gives the corrected digit for sums 10..19.
        digit    = carryOut ? (binSum[3:0] - BCD_TEN[3:0]) : binSum[3:0];
    end

endmodule

// File: rtl/bcd_serial_addsub.sv
// Multi-digit BCD adder/subtractor, one digit per clock, LSD first, sign-magnitude result.
module bcd_serial_addsub
    import bcd_pkg::*;
#(
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [4*DIGITS-1:0] a,
    input  logic [4*DIGITS-1:0] b,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] sum,
    output logic                carry_out,
    output logic                neg,
    output logic                err
);

    localparam int               WIDTH     = 4 * DIGITS;
    localparam int               IDX_W     = $clog2(DIGITS + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(DIGITS - 1);
    localparam int               TOP_SHIFT = 4 * (DIGITS - 1);

    bcd_state_e       state;
    logic [IDX_W-1:0] digitIdx;
    logic             carry;
    logic [WIDTH-1:0] aShift;
    logic [WIDTH-1:0] bShift;
    logic             isSub;
    logic [WIDTH-1:0] result;
    logic             carryOutReg;
    logic             negReg;
    logic             errReg;

    logic             operandsBad;
    bcd_digit_t       addX;
    bcd_digit_t       addY;
    bcd_digit_t       addDigit;
    logic             addCarry;
    logic [WIDTH-1:0] nextResult;

    // Flag any non-decimal digit in either operand at the accept boundary.
    always_comb begin
        operandsBad = 1'b0;
        for (int i = 0; i < DIGITS; i++) begin
            if (!bcd_is_valid(a[4*i +: 4]) || !bcd_is_valid(b[4*i +: 4])) begin
                operandsBad = 1'b1;
            end
        end
    end

    // Operand mux for the shared digit adder: A + B (or A + 9-B) in ADD, 9 - result in COMP.
    always_comb begin
        addX = aShift[3:0];
        addY = isSub ? (BCD_NINE - bShift[3:0]) : bShift[3:0];
        if (state == S_COMP) begin
            addX = BCD_NINE - result[3:0];
            addY = '0;
        end
    end

    bcd_digit_adder u_digitAdder (
        .x        (addX),
        .y        (addY),
        .carryIn  (carry),
        .digit    (addDigit),
        .carryOut (addCarry)
    );

    // Operands and result are shift registers: the current digit is always in bits [3:0],
    // and each new result digit enters at the top so DIGITS shifts leave it in place.
    assign nextResult = (result >> 4) | (WIDTH'(addDigit) << TOP_SHIFT);

    // Control FSM, digit counter, carry and result registers.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state       <= S_IDLE;
            digitIdx    <= '0;
            carry       <= 1'b0;
            aShift      <= '0;
            bShift      <= '0;
            isSub       <= 1'b0;
            result      <= '0;
            carryOutReg <= 1'b0;
            negReg      <= 1'b0;
            errReg      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (in_valid && in_ready) begin
                        aShift      <= a;
                        bShift      <= b;
                        isSub       <= sub;
                        digitIdx    <= '0;
                        carry       <= sub;
                        result      <= '0;
                        carryOutReg <= 1'b0;
                        negReg      <= 1'b0;
                        errReg      <= operandsBad;
                        state       <= operandsBad ? S_DONE : S_ADD;
                    end
                end
                S_ADD: begin
                    result   <= nextResult;
                    aShift   <= aShift >> 4;
                    bShift   <= bShift >> 4;
                    carry    <= addCarry;
                    digitIdx <= digitIdx + 1'b1;
                    if (digitIdx == LAST_IDX) begin
                        if (!isSub) begin
                            carryOutReg <= addCarry;
                            state       <= S_DONE;
                        end else if (addCarry) begin
                            state <= S_DONE;
                        end else begin
                            // No end-around carry: the ten's-complement result is negative.
                            negReg   <= 1'b1;
                            digitIdx <= '0;
                            carry    <= 1'b1;
                            state    <= S_COMP;
                        end
                    end
                end
                S_COMP: begin
                    result   <= nextResult;
                    carry    <= addCarry;
                    digitIdx <= digitIdx + 1'b1;
                    if (digitIdx == LAST_IDX) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // in_ready is gated by resetn so it reads low during reset, not just after the first edge.
    assign in_ready  = (state == S_IDLE) && resetn;
    assign out_valid = (state == S_DONE);
    assign sum       = result;
    assign carry_out = carryOutReg;
    assign neg       = negReg;
    assign err       = errReg;

endmodule

// File: tb/tb_bcd_serial_addsub.sv
// Scoreboard bench for bcd_serial_addsub: directed vectors, queue-based result monitor.
module tb_bcd_serial_addsub;

    // ---------------- DIGITS=4 instance ----------------
    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] a = '0;
    logic [15:0] b = '0;
    logic        sub = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] sum;
    logic        carry_out;
    logic        neg;
    logic        err;

    bcd_serial_addsub #(.DIGITS(4)) dut (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry_out (carry_out),
        .neg       (neg),
        .err       (err)
    );

    // ---------------- DIGITS=1 instance ----------------
    logic       inValid1 = 1'b0;
    logic       inReady1;
    logic [3:0] a1 = '0;
    logic [3:0] b1 = '0;
    logic       sub1 = 1'b0;
    logic       outValid1;
    logic       outReady1 = 1'b1;
    logic [3:0] sum1;
    logic       carry1;
    logic       neg1;
    logic       err1;

    bcd_serial_addsub #(.DIGITS(1)) dut1 (
        .clk       (clk),
        .resetn    (resetn),
        .in_valid  (inValid1),
        .in_ready  (inReady1),
        .a         (a1),
        .b         (b1),
        .sub       (sub1),
        .out_valid (outValid1),
        .out_ready (outReady1),
        .sum       (sum1),
        .carry_out (carry1),
        .neg       (neg1),
        .err       (err1)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [15:0] sum;
        logic        c;
        logic        n;
        logic        e;
        int          lat;
        int          acc;
        int          id;
    } exp_t;

    exp_t expQ[$];
    exp_t monE;
    int   total = 0;
    int   bad = 0;
    int   opId = 0;
    logic prevOv = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Monitor: on each rising out_valid, pop the oldest expectation and compare.
    always @(negedge clk) begin
        if (out_valid && !prevOv) begin
            if (expQ.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_result: got sum=%0h with empty scoreboard", sum);
            end else begin
                monE = expQ.pop_front();
                check($sformatf("op%0d_sum", monE.id), 32'(sum), 32'(monE.sum));
                check($sformatf("op%0d_carry", monE.id), 32'(carry_out), 32'(monE.c));
                check($sformatf("op%0d_neg", monE.id), 32'(neg), 32'(monE.n));
                check($sformatf("op%0d_err", monE.id), 32'(err), 32'(monE.e));
                check($sformatf("op%0d_latency", monE.id), 32'(cyc - monE.acc), 32'(monE.lat));
            end
        end
        prevOv = out_valid;
    end

    // Present one operation; push its expectation keyed to the acceptance edge.
    task automatic issue(input logic [15:0] ta, input logic [15:0] tb_, input logic ts,
                         input logic [15:0] es, input logic ec, input logic en,
                         input logic ee, input int el, input bit junk);
        exp_t x;
        int   guard;
        @(negedge clk);
        a = ta; b = tb_; sub = ts; in_valid = 1'b1;
        guard = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        opId++;
        if (!in_ready) begin
            total++;
            bad++;
            $display("FAIL op%0d_accept: got in_ready=0 want 1 within 50 cycles", opId);
            in_valid = 1'b0;
            return;
        end
        x.sum = es; x.c = ec; x.n = en; x.e = ee; x.lat = el; x.acc = cyc + 1; x.id = opId;
        expQ.push_back(x);
        @(posedge clk);
        #1;
        if (junk) begin
            // Keep in_valid asserted with different operands while busy: must be ignored.
            a = 16'h9999; b = 16'h0001; sub = ~ts;
            @(negedge clk);
            @(negedge clk);
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_done();
        int g = 0;
        while (expQ.size() != 0 && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (expQ.size() != 0) begin
            total++;
            bad++;
            $display("FAIL result_timeout: got pending=%0d want 0", expQ.size());
            expQ.delete();
        end
    endtask

    // Direct check for the single-digit instance.
    task automatic run1(input logic [3:0] ta, input logic [3:0] tb_, input logic ts,
                        input logic [3:0] es, input logic ec, input logic en, input int el);
        int g;
        int acc;
        @(negedge clk);
        a1 = ta; b1 = tb_; sub1 = ts; inValid1 = 1'b1;
        g = 0;
        while (!inReady1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        acc = cyc + 1;
        @(posedge clk);
        #1;
        inValid1 = 1'b0;
        g = 0;
        @(negedge clk);
        while (!outValid1 && g < 20) begin
            @(negedge clk);
            g++;
        end
        check("d1_out_valid", 32'(outValid1), 32'd1);
        check("d1_latency", 32'(cyc - acc), 32'(el));
        check("d1_sum", 32'(sum1), 32'(es));
        check("d1_carry", 32'(carry1), 32'(ec));
        check("d1_neg", 32'(neg1), 32'(en));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test want finish before 200us");
        $fatal(1);
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_sum", 32'(sum), 32'd0);
        check("rst_flags", 32'({carry_out, neg, err}), 32'd0);
        resetn = 1'b1;
        @(negedge clk);
        check("post_rst_in_ready", 32'(in_ready), 32'd1);

        // Add cases.
        issue(16'h1234, 16'h8766, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 1'b0); wait_done();
        issue(16'h2345, 16'h1111, 1'b0, 16'h3456, 1'b0, 1'b0, 1'b0, 4, 1'b0); wait_done();
        issue(16'h9999, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 1'b0); wait_done();
        // Subtract cases: non-negative, negative, equal, boundaries.
        issue(16'h0500, 16'h0123, 1'b1, 16'h0377, 1'b0, 1'b0, 1'b0, 4, 1'b0); wait_done();
        issue(16'h0123, 16'h0500, 1'b1, 16'h0377, 1'b0, 1'b1, 1'b0, 8, 1'b0); wait_done();
        issue(16'h4321, 16'h4321, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b0, 4, 1'b0); wait_done();
        issue(16'h0000, 16'h0001, 1'b1, 16'h0001, 1'b0, 1'b1, 1'b0, 8, 1'b0); wait_done();
        issue(16'h9999, 16'h0000, 1'b1, 16'h9999, 1'b0, 1'b0, 1'b0, 4, 1'b0); wait_done();
        // in_valid held with changing operands while busy.
        issue(16'h5000, 16'h5000, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0, 4, 1'b1); wait_done();
        // Invalid digits, then a clean op clears err.
        issue(16'h00A0, 16'h0001, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b0); wait_done();
        issue(16'h0001, 16'hF000, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 0, 1'b0); wait_done();
        issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4, 1'b0); wait_done();

        // Backpressure: hold DONE for 5 cycles.
        out_ready = 1'b0;
        issue(16'h0042, 16'h0058, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0, 4, 1'b0); wait_done();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("bp%0d_out_valid", k), 32'(out_valid), 32'd1);
            check($sformatf("bp%0d_sum", k), 32'(sum), 32'h0100);
            check($sformatf("bp%0d_flags", k), 32'({carry_out, neg, err}), 32'd0);
            check($sformatf("bp%0d_in_ready", k), 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_in_ready", 32'(in_ready), 32'd1);
        check("bp_release_out_valid", 32'(out_valid), 32'd0);
        check("bp_release_sum_held", 32'(sum), 32'h0100);

        // Reset two edges into an ADD.
        issue(16'h1111, 16'h2222, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0, 4, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("midrst_sum", 32'(sum), 32'd0);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_flags", 32'({carry_out, neg, err}), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        expQ.delete();
        @(negedge clk);
        resetn = 1'b1;
        issue(16'h0001, 16'h0002, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0, 4, 1'b0); wait_done();

        // Single-digit instance.
        run1(4'd9, 4'd9, 1'b0, 4'd8, 1'b1, 1'b0, 1);
        run1(4'd5, 4'd7, 1'b1, 4'd2, 1'b0, 1'b1, 2);
        run1(4'd7, 4'd5, 1'b1, 4'd2, 1'b0, 1'b0, 1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bcd_serial_addsub.md
# bcd_serial_addsub

Parametrised multi-digit BCD adder/subtractor. It processes one decimal digit per clock, least significant digit first, through a single shared digit adder. Subtraction uses ten's complement, followed by an optional complement pass so the result is always sign plus magnitude. It succeeds the fixed two-digit combinational BCD adder, sits behind a valid/ready operand interface and presents a held result with its own valid/ready handshake.

## Interface
- `DIGITS`, default 4: number of BCD digits per operand and result; legal range ≥1.
- `clk`  in  1: sole clock; all state updates on the rising edge.
- `resetn`  in  1: asynchronous, active-low reset.
- `in_valid`  in  1: operands and mode presented.
- `in_ready`  out  1: block can accept; high only in IDLE and while `resetn`=1.
- `a`  in  4*DIGITS: operand A, packed BCD, digit 0 in bits [3:0].
- `b`  in  4*DIGITS: operand B, packed BCD.
- `sub`  in  1: 0 = A+B, 1 = A−B.
- `out_valid`  out  1: result registers valid.
- `out_ready`  in  1: consumer takes the result.
- `sum`  out  4*DIGITS: result magnitude, packed BCD.
- `carry_out`  out  1: add only; 1 when A+B ≥ 10^DIGITS. Always 0 for sub.
- `neg`  out  1: sub only; 1 when A<B.
- `err`  out  1: an input digit exceeded 9.

## Operation
- States: IDLE, ADD, COMP, DONE.
- Acceptance: `in_valid`&`in_ready` at a rising edge. At that edge the block latches A, B and `sub`, sets the digit index to 0 and clears the result registers.
- Accept with any digit of A or B >9: go straight to DONE with `sum`=0, `carry_out`=0, `neg`=0, `err`=1. No arithmetic is performed.
- Accept with valid digits: go to ADD.
  - Running carry initialises to `sub` (0 for add, 1 for sub).
- ADD, one digit per edge:
  - Digit operand is A[i] and B'[i], where B'[i] = B[i] for add and 9−B[i] for sub.
  - Digit result = (A[i]+B'[i]+carry) corrected to BCD; if the binary sum is ≥10, subtract 10 and set carry.
  - Write sum[i]; increment i.
- After digit DIGITS−1:
  - Add: `carry_out` = final carry; go to DONE.
  - Sub with final carry 1: result is non-negative; `neg`=0; go to DONE.
  - Sub with final carry 0: result is negative; `neg`=1; reset i=0 and carry=1; go to COMP.
- COMP, one digit per edge: sum[i] ← BCD(9−sum[i]+carry), with carry propagated as in ADD. After digit DIGITS−1 go to DONE.
- DONE: `out_valid`=1. The block stays in DONE until `out_ready`=1 at an edge, then goes to IDLE.
  - `sum` and the flags hold until the next acceptance.
- A−A yields `sum`=0 and `neg`=0; there is no negative zero.

## Timing
- Reset values: `out_valid`=0, `sum`=0, `carry_out`=0, `neg`=0, `err`=0. State is IDLE; `in_ready`=0 while `resetn`=0 and 1 after release.
- Latency is counted in edges from the acceptance edge to the edge that raises `out_valid`:
  - add: DIGITS
  - non-negative sub: DIGITS
  - negative sub: 2·DIGITS
  - err: 0, i.e. `out_valid` is high in the cycle right after acceptance.
- `in_ready` and `out_valid` are never high together; a new operand cannot be accepted in the cycle the result is taken.
- `out_ready` asserted outside DONE is ignored.
- `in_valid` outside IDLE is ignored, and operand inputs may change freely.
- Reset asserted mid-ADD, mid-COMP or in DONE: the operation is lost and all outputs immediately take their reset values.
- Throughput: one operation per DIGITS+2 cycles minimum (add, `out_ready` held high).

## Structure
- Package `bcd_pkg` holds:
  - typedef `bcd_digit_t` (4 bits)
  - state enum `bcd_state_e`
  - constant `BCD_NINE`=4'd9 and constant `BCD_TEN`=5'd10
  - function `bcd_is_valid(digit)`.
- Sub-module `bcd_digit_adder`: combinational. Inputs are two digits and carry-in; outputs are the corrected digit and carry-out. It is the only arithmetic instance and is shared by ADD and COMP through operand muxing.
- Top level holds: FSM, digit index counter of width $clog2(DIGITS+1), carry flop, and a result shift/indexed register.

## Test plan
- DIGITS=4, add 1234+8766, `out_ready`=1 → `sum`=0000, `carry_out`=1, `neg`=0; `out_valid` 4 edges after accept.
- DIGITS=4, sub 0500−0123 → `sum`=0377, `neg`=0, latency 4. Then sub 0123−0500 → `sum`=0377, `neg`=1, latency 8.
- DIGITS=4, sub 4321−4321 → `sum`=0000, `neg`=0, `carry_out`=0. DIGITS=1, add 9+9 → `sum`=8, `carry_out`=1.
- A=0x00A0 with B=0x0001 → `err`=1, `sum`=0, `out_valid` in the next cycle; the following valid operation clears `err`.
- Backpressure: hold `out_ready`=0 for 5 cycles in DONE → `out_valid`, `sum` and flags stable and `in_ready`=0; raise `out_ready` → IDLE, `in_ready`=1 next cycle.
- Drop `resetn` two edges into an ADD → all outputs 0 at once; after release, a fresh 0001+0002 → `sum`=0003 with latency 4.
